universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving bits per stage (minimum 1).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of stages (minimum 2).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port clr, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port en, input, 1 bit: operation enable; when 0, all state holds.
REQ-006 The module SHALL have port mode, input, 2 bits: 00 HOLD, 01 SHR (toward high index), 10 SHL (toward low index), 11 LOAD.
REQ-007 The module SHALL have port sin_lo, input, WIDTH bits: serial data entering stage 0 on SHR.
REQ-008 The module SHALL have port sin_hi, input, WIDTH bits: serial data entering stage DEPTH-1 on SHL.
REQ-009 The module SHALL have port pdata, input, DEPTH*WIDTH bits: parallel load data; stage i maps to bits [i*WIDTH +: WIDTH].
REQ-010 The module SHALL have port pout, output, DEPTH*WIDTH bits: all stages, using the pdata mapping.
REQ-011 The module SHALL have port sout_hi, output, WIDTH bits, equal to stage DEPTH-1.
REQ-012 The module SHALL have port sout_lo, output, WIDTH bits, equal to stage 0.
REQ-013 The module SHALL have port fill, output, $clog2(DEPTH+1) bits: the count of stages holding valid data.
REQ-014 The module SHALL have port full, output, 1 bit, asserted when fill equals DEPTH.

Function
REQ-015 All outputs SHALL be driven from state registers only: one-cycle latency from input to output, with no combinational input-to-output path.
REQ-016 HOLD, or en=0, SHALL leave all stages and fill unchanged.
REQ-017 SHR SHALL perform stage[i] <= stage[i-1] for i = 1 to DEPTH-1 and stage[0] <= sin_lo, with all stages updating concurrently and independent of evaluation order.
REQ-018 SHL SHALL perform stage[i] <= stage[i+1] for i = 0 to DEPTH-2 and stage[DEPTH-1] <= sin_hi.
REQ-019 LOAD SHALL replace all stages with pdata and set fill to DEPTH.
REQ-020 SHR and SHL SHALL increment fill by 1, saturating at DEPTH with no wrap to 0.
REQ-021 The data shifted out on each shift SHALL be visible on sout_hi (SHR) or sout_lo (SHL) during the cycle before the shifting edge.
REQ-022 full SHALL be registered alongside fill, never lagging it by a cycle.

Reset
REQ-023 When clr=0 at a clk edge, every stage, fill and full SHALL become 0, with reset taking priority over en and mode.
REQ-024 A reset asserted in the middle of a shift sequence SHALL discard the in-flight operation; the first edge with clr=1 SHALL execute the mode presented on that edge.

Configuration
REQ-025 When macro USR_ROTATE_EN is defined, the module SHALL add input port rot (1 bit); with rot=1, SHR loads stage[0] from the old stage[DEPTH-1] and SHL loads stage[DEPTH-1] from the old stage[0], ignoring sin_lo/sin_hi and leaving fill unchanged.
REQ-026 When USR_ROTATE_EN is undefined, the rot port and the rotate logic SHALL be absent, and shifts SHALL always take sin_lo/sin_hi.

Structure
REQ-027 A shared package usr_pkg SHALL hold the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD as a 2-bit typedef.
REQ-028 Each stage SHALL be an instance of sub-module usr_stage, a WIDTH-bit register with a 4:1 next-value mux (hold/left/right/load); the top level SHALL own fill, full and the generate loop.

Verification (WIDTH=4, DEPTH=4)
REQ-029 The bench SHALL check: clr=0 for 1 edge -> pout=16'h0000, fill=0, full=0.
REQ-030 The bench SHALL check: LOAD pdata=16'h4321 -> next cycle pout=16'h4321, fill=4, full=1, sout_hi=4'h4, sout_lo=4'h1.
REQ-031 The bench SHALL check: after reset, 5 x SHR with sin_lo=A,B,C,D,E -> pout=16'hBCDE, fill saturates at 4, and full rises after the 4th edge.
REQ-032 The bench SHALL check: from 16'h4321, SHL sin_hi=4'hF -> pout=16'hF432; then en=0 with mode=SHR for 3 cycles -> pout unchanged.
REQ-033 The bench SHALL check: from 16'h4321 with USR_ROTATE_EN defined, rot=1 and SHR -> pout=16'h3214; rot=1 and SHL -> back to 16'h4321; fill stays 4.
REQ-034 The bench SHALL check: SHR sequence in progress at fill=2, clr=0 on the same edge as mode=LOAD -> pout=0, fill=0; the next edge with clr=1 and LOAD applies pdata.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Holds the 2-bit mode encoding used by the top level and by every stage.
package usr_pkg;

    // Operating mode presented on the mode port.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,  // keep contents
        MODE_SHR  = 2'b01,  // shift toward high index, sin_lo enters stage 0
        MODE_SHL  = 2'b10,  // shift toward low index, sin_hi enters stage DEPTH-1
        MODE_LOAD = 2'b11   // parallel load from pdata
    } usr_mode_t;

endpackage

// File: rtl/usr_stage.sv
// One WIDTH-bit storage stage of the universal shift register.
// A 4:1 next-value mux picks hold / value from the lower-index neighbour (SHR) /
// value from the higher-index neighbour (SHL) / parallel load data.
// Clear is synchronous and active-low, and it overrides the selected mode.
import usr_pkg::*;

module usr_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  usr_mode_t        sel_i,
    input  logic [WIDTH-1:0] right_i,  // taken on SHR (neighbour at index-1 or serial-in)
    input  logic [WIDTH-1:0] left_i,   // taken on SHL (neighbour at index+1 or serial-in)
    input  logic [WIDTH-1:0] load_i,   // taken on LOAD
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-value mux; hold is the default so an unexpected select cannot corrupt data.
    always_comb begin
        data_d = data_q;
        unique case (sel_i)
            MODE_HOLD: data_d = data_q;
            MODE_SHR:  data_d = right_i;
            MODE_SHL:  data_d = left_i;
            MODE_LOAD: data_d = load_i;
            default:   data_d = data_q;
        endcase
    end

    // Stage register with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, shift right
// (toward high index), shift left (toward low index) and parallel load.
// A fill counter tracks how many stages hold valid data; full is registered
// with it so the two never disagree.
// Optional feature: define USR_ROTATE_EN to add the rot input, which turns
// shifts into rotations (serial inputs ignored, fill unchanged).
// All outputs come straight from registers.
import usr_pkg::*;

module universal_shift_reg #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic [1:0]                 mode,
`ifdef USR_ROTATE_EN
    input  logic                       rot,
`endif
    input  logic [WIDTH-1:0]           sin_lo,
    input  logic [WIDTH-1:0]           sin_hi,
    input  logic [DEPTH*WIDTH-1:0]     pdata,
    output logic [DEPTH*WIDTH-1:0]     pout,
    output logic [WIDTH-1:0]           sout_hi,
    output logic [WIDTH-1:0]           sout_lo,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full
);

    localparam int FW = $clog2(DEPTH+1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    // Effective operation: a disabled register behaves exactly like HOLD.
    usr_mode_t op;
    assign op = en ? usr_mode_t'(mode) : MODE_HOLD;

    // Concatenated stage outputs, stage i at [i*WIDTH +: WIDTH].
    logic [DEPTH*WIDTH-1:0] stages;

    // Serial data entering the end stages, and whether a shift counts toward fill.
    logic [WIDTH-1:0] ser_lo;
    logic [WIDTH-1:0] ser_hi;
    logic             shift_fills;

`ifdef USR_ROTATE_EN
    // Rotation wraps the far end stage around instead of taking serial data.
    assign ser_lo      = rot ? stages[(DEPTH-1)*WIDTH +: WIDTH] : sin_lo;
    assign ser_hi      = rot ? stages[0 +: WIDTH] : sin_hi;
    assign shift_fills = ~rot;
`else
    assign ser_lo      = sin_lo;
    assign ser_hi      = sin_hi;
    assign shift_fills = 1'b1;
`endif

    // One stage per index; neighbours are wired so all stages update concurrently.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] right_src;
        logic [WIDTH-1:0] left_src;

        if (i == 0) begin : g_lo_end
            assign right_src = ser_lo;
        end else begin : g_lo_mid
            assign right_src = stages[(i-1)*WIDTH +: WIDTH];
        end

        if (i == DEPTH-1) begin : g_hi_end
            assign left_src = ser_hi;
        end else begin : g_hi_mid
            assign left_src = stages[(i+1)*WIDTH +: WIDTH];
        end

        usr_stage #(.WIDTH(WIDTH)) u_stage (
            .clk_i   (clk),
            .clr_i   (clr),
            .sel_i   (op),
            .right_i (right_src),
            .left_i  (left_src),
            .load_i  (pdata[i*WIDTH +: WIDTH]),
            .q_o     (stages[i*WIDTH +: WIDTH])
        );
    end

    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic          full_q;
    logic          full_d;

    // Fill bookkeeping: shifts count up and saturate, load fills every stage.
    always_comb begin
        fill_d = fill_q;
        unique case (op)
            MODE_SHR, MODE_SHL: begin
                if (shift_fills && (fill_q != FILL_MAX)) begin
                    fill_d = fill_q + FW'(1);
                end
            end
            MODE_LOAD: fill_d = FILL_MAX;
            default:   fill_d = fill_q;
        endcase
        full_d = (fill_d == FILL_MAX);
    end

    // Fill and full registers, cleared together with the stages.
    always_ff @(posedge clk) begin
        if (!clr) begin
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
            full_q <= full_d;
        end
    end

    assign pout    = stages;
    assign sout_hi = stages[(DEPTH-1)*WIDTH +: WIDTH];
    assign sout_lo = stages[0 +: WIDTH];
    assign fill    = fill_q;
    assign full    = full_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed plus short random bench for universal_shift_reg (WIDTH=4, DEPTH=4).
// Define USR_ROTATE_EN to also exercise the rotate feature.
module tb_universal_shift_reg;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int FW = $clog2(D+1);
    localparam int EW = D*W + FW + 1;

    logic           clk;
    logic           clr;
    logic           en;
    logic [1:0]     mode;
    logic           rot;
    logic [W-1:0]   sin_lo;
    logic [W-1:0]   sin_hi;
    logic [D*W-1:0] pdata;
    logic [D*W-1:0] pout;
    logic [W-1:0]   sout_hi;
    logic [W-1:0]   sout_lo;
    logic [FW-1:0]  fill;
    logic           full;

    int checks = 0;
    int errors = 0;

    // Expected {pout, fill, full} after each driven edge.
    logic [EW-1:0] exp_q[$];

    // Reference model state.
    logic [W-1:0] m_st[D];
    int           m_fill;

    universal_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .mode    (mode),
`ifdef USR_ROTATE_EN
        .rot     (rot),
`endif
        .sin_lo  (sin_lo),
        .sin_hi  (sin_hi),
        .pdata   (pdata),
        .pout    (pout),
        .sout_hi (sout_hi),
        .sout_lo (sout_lo),
        .fill    (fill),
        .full    (full)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge and queue the expected outputs.
    task automatic model_step(input logic c, input logic e, input logic [1:0] m,
                              input logic r, input logic [W-1:0] lo,
                              input logic [W-1:0] hi, input logic [D*W-1:0] pd);
        logic [W-1:0]   old[D];
        logic [D*W-1:0] flat;
        for (int i = 0; i < D; i++) old[i] = m_st[i];
        if (!c) begin
            for (int i = 0; i < D; i++) m_st[i] = '0;
            m_fill = 0;
        end else if (e) begin
            case (m)
                2'b01: begin
                    for (int i = 1; i < D; i++) m_st[i] = old[i-1];
                    m_st[0] = r ? old[D-1] : lo;
                    if (!r && m_fill < D) m_fill++;
                end
                2'b10: begin
                    for (int i = 0; i < D-1; i++) m_st[i] = old[i+1];
                    m_st[D-1] = r ? old[0] : hi;
                    if (!r && m_fill < D) m_fill++;
                end
                2'b11: begin
                    for (int i = 0; i < D; i++) m_st[i] = pd[i*W +: W];
                    m_fill = D;
                end
                default: ;
            endcase
        end
        for (int i = 0; i < D; i++) flat[i*W +: W] = m_st[i];
        exp_q.push_back({flat, FW'(m_fill), (m_fill == D)});
    endtask

    // Pop one expectation and compare every output against it.
    task automatic check_outputs(input string tag);
        logic [EW-1:0]  e;
        logic [D*W-1:0] e_pout;
        logic [FW-1:0]  e_fill;
        logic           e_full;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            {e_pout, e_fill, e_full} = e;
            check_vec({tag, "_pout"},    32'(pout),    32'(e_pout));
            check_vec({tag, "_fill"},    32'(fill),    32'(e_fill));
            check_vec({tag, "_full"},    32'(full),    32'(e_full));
            check_vec({tag, "_sout_hi"}, 32'(sout_hi), 32'(e_pout[(D-1)*W +: W]));
            check_vec({tag, "_sout_lo"}, 32'(sout_lo), 32'(e_pout[0 +: W]));
        end
    endtask

    // Drive one cycle of stimulus, then check just after the edge.
    task automatic step(input string tag, input logic c, input logic e,
                        input logic [1:0] m, input logic r, input logic [W-1:0] lo,
                        input logic [W-1:0] hi, input logic [D*W-1:0] pd);
        clr = c; en = e; mode = m; rot = r; sin_lo = lo; sin_hi = hi; pdata = pd;
        model_step(c, e, m, r, lo, hi, pd);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [W-1:0] shr_seq[5];
        logic         r_rot;
        shr_seq = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        for (int i = 0; i < D; i++) m_st[i] = '0;
        m_fill = 0;
        clr = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0;
        sin_lo = '0; sin_hi = '0; pdata = '0;

        // Reset state.
        step("reset", 1'b0, 1'b1, 2'b11, 1'b0, 4'h0, 4'h0, 16'hFFFF);
        check_vec("reset_pout_const", 32'(pout), 32'h0);

        // Parallel load.
        step("load", 1'b1, 1'b1, 2'b11, 1'b0, 4'h0, 4'h0, 16'h4321);
        check_vec("load_pout_const", 32'(pout), 32'h4321);
        check_vec("load_sout_hi_const", 32'(sout_hi), 32'h4);
        check_vec("load_sout_lo_const", 32'(sout_lo), 32'h1);

        // Five shifts right from reset: fill saturates, full rises after the 4th edge.
        step("reset2", 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 4'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step("shr", 1'b1, 1'b1, 2'b01, 1'b0, shr_seq[i], 4'h0, 16'h0);
            check_vec("shr_full_edge", 32'(full), (i >= 3) ? 32'd1 : 32'd0);
        end
        check_vec("shr_pout_const", 32'(pout), 32'hBCDE);
        check_vec("shr_fill_const", 32'(fill), 32'd4);

        // Shift left from a loaded pattern, then a disabled SHR must hold.
        step("load2", 1'b1, 1'b1, 2'b11, 1'b0, 4'h0, 4'h0, 16'h4321);
        step("shl", 1'b1, 1'b1, 2'b10, 1'b0, 4'h0, 4'hF, 16'h0);
        check_vec("shl_pout_const", 32'(pout), 32'hF432);
        for (int i = 0; i < 3; i++) begin
            step("en_off", 1'b1, 1'b0, 2'b01, 1'b0, 4'h7, 4'h7, 16'h0);
        end
        check_vec("en_off_pout_const", 32'(pout), 32'hF432);

        // Plain HOLD with en=1 and partial fill.
        step("reset3", 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 4'h0, 16'h0);
        step("shl_part", 1'b1, 1'b1, 2'b10, 1'b0, 4'h0, 4'h9, 16'h0);
        step("hold", 1'b1, 1'b1, 2'b00, 1'b0, 4'h3, 4'h3, 16'hAAAA);

`ifdef USR_ROTATE_EN
        // Rotation leaves fill at its current value.
        step("load3", 1'b1, 1'b1, 2'b11, 1'b0, 4'h0, 4'h0, 16'h4321);
        step("rot_shr", 1'b1, 1'b1, 2'b01, 1'b1, 4'h8, 4'h8, 16'h0);
        check_vec("rot_shr_pout_const", 32'(pout), 32'h3214);
        step("rot_shl", 1'b1, 1'b1, 2'b10, 1'b1, 4'h8, 4'h8, 16'h0);
        check_vec("rot_shl_pout_const", 32'(pout), 32'h4321);
        check_vec("rot_fill_const", 32'(fill), 32'd4);
`endif

        // Reset in the middle of a shift sequence, with LOAD on the same edge.
        step("mid_reset0", 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 4'h0, 16'h0);
        step("mid_shr1", 1'b1, 1'b1, 2'b01, 1'b0, 4'h5, 4'h0, 16'h0);
        step("mid_shr2", 1'b1, 1'b1, 2'b01, 1'b0, 4'h6, 4'h0, 16'h0);
        check_vec("mid_fill_const", 32'(fill), 32'd2);
        step("mid_clr_load", 1'b0, 1'b1, 2'b11, 1'b0, 4'h0, 4'h0, 16'h9876);
        check_vec("mid_clr_pout_const", 32'(pout), 32'h0);
        step("post_clr_load", 1'b1, 1'b1, 2'b11, 1'b0, 4'h0, 4'h0, 16'h9876);
        check_vec("post_clr_pout_const", 32'(pout), 32'h9876);

        // Random operations against the model.
        step("rnd_reset", 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 4'h0, 16'h0);
        for (int i = 0; i < 40; i++) begin
`ifdef USR_ROTATE_EN
            r_rot = 1'($urandom_range(0, 3) == 0);
`else
            r_rot = 1'b0;
`endif
            step("rnd",
                 1'($urandom_range(0, 15) != 0),
                 1'($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)),
                 r_rot,
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 65535)));
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
